// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-branch unit: condition codes,
// NZCV flag bit positions and the FSM state type.
package cond_pkg;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5;
  localparam logic [3:0] CC_VS = 4'd6;
  localparam logic [3:0] CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8;
  localparam logic [3:0] CC_LS = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12;
  localparam logic [3:0] CC_LE = 4'd13;
  localparam logic [3:0] CC_AL = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: (NZCV flags, code) -> taken.
// Kept standalone so predicated-execution logic can reuse it.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] code,
  output logic       taken
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    // NOTE: the default assignment ahead of the case keeps every path driven, so no latch is inferred.
    taken = 1'b0;
    case (code)
      CC_EQ: taken = z;
      CC_NE: taken = !z;
      CC_CS: taken = c;
      CC_CC: taken = !c;
      CC_MI: taken = n;
      CC_PL: taken = !n;
      CC_VS: taken = v;
      CC_VC: taken = !v;
      CC_HI: taken = c && !z;
      CC_LS: taken = !c || z;
      CC_GE: taken = (n == v);
      CC_LT: taken = (n != v);
      CC_GT: taken = !z && (n == v);
      CC_LE: taken = z || (n != v);
      CC_AL: taken = 1'b1;
      CC_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_branch_unit.sv
// Execute-stage conditional-branch unit: NZCV flag register, branch evaluation,
// one-cycle PC redirect and a FLUSH_CYCLES-long flush. Define COND_FWD_EN to
// let a same-cycle set_cond feed the branch evaluation.
module cond_branch_unit
  import cond_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        cond_in,
  input  logic              set_cond,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_code,
  input  logic [ADDR_W-1:0] br_target,
  output logic              pc_redirect_valid,
  output logic [ADDR_W-1:0] pc_redirect,
  output logic              flush,
  output logic [3:0]        flags,
  output logic              busy
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] flush_cnt;
  logic [3:0] eval_flags;
  logic       br_taken;

`ifdef COND_FWD_EN
  assign eval_flags = set_cond ? cond_in : flags;
`else
  assign eval_flags = flags;
`endif

  cond_eval u_cond_eval (
    .flags (eval_flags),
    .code  (br_code),
    .taken (br_taken)
  );

  assign br_ready = (state == ST_IDLE);
  assign busy     = (state == ST_FLUSH);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      flush_cnt         <= 4'd0;
      flags             <= 4'd0;
      flush             <= 1'b0;
      pc_redirect_valid <= 1'b0;
      pc_redirect       <= '0;
    end else begin
      pc_redirect_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (set_cond) flags <= cond_in;
          if (br_valid && br_taken) begin
            state             <= ST_FLUSH;
            flush_cnt         <= FLUSH_LOAD;
            flush             <= 1'b1;
            pc_redirect_valid <= 1'b1;
            pc_redirect       <= br_target;
          end
        end
        ST_FLUSH: begin
          // Flag writes here come from squashed instructions and are dropped.
          if (flush_cnt == 4'd0) begin
            state <= ST_IDLE;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cond_branch_unit.sv
// Self-checking bench for cond_branch_unit: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
module tb_cond_branch_unit;

  localparam int ADDR_W       = 16;
  localparam int FLUSH_CYCLES = 2;
`ifdef COND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        cond_in = '0;
  logic              set_cond = 1'b0;
  logic              br_valid = 1'b0;
  logic              br_ready;
  logic [3:0]        br_code = '0;
  logic [ADDR_W-1:0] br_target = '0;
  logic              pc_redirect_valid;
  logic [ADDR_W-1:0] pc_redirect;
  logic              flush;
  logic [3:0]        flags;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  cond_branch_unit #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cond_in           (cond_in),
    .set_cond          (set_cond),
    .br_valid          (br_valid),
    .br_ready          (br_ready),
    .br_code           (br_code),
    .br_target         (br_target),
    .pc_redirect_valid (pc_redirect_valid),
    .pc_redirect       (pc_redirect),
    .flush             (flush),
    .flags             (flags),
    .busy              (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Condition table written directly from the ARM-style NZCV definitions.
  function automatic bit cond_true(input logic [3:0] code, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code)
      0: return z;          1: return !z;
      2: return c;          3: return !c;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return c & !z;     9: return !c | z;
      10: return n == v;    11: return n != v;
      12: return !z & (n == v);
      13: return z | (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Model: cycles of flush still ahead; zero means the unit is ready.
  logic [3:0]        m_flags;
  int                m_left;
  bit                m_rv;
  logic [ADDR_W-1:0] m_pc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flags = 4'd0; m_left = 0; m_rv = 1'b0; m_pc = '0;
    end else begin
      bit         ready, taken;
      logic [3:0] src;
      ready = (m_left == 0);
      src   = (FWD && set_cond) ? cond_in : m_flags;
      taken = br_valid && ready && cond_true(br_code, src);
      m_rv  = taken;
      if (taken) begin
        m_pc   = br_target;
        m_left = FLUSH_CYCLES;
      end else if (m_left > 0) begin
        m_left--;
      end
      if (set_cond && ready) m_flags = cond_in;
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("cmp_flags", 32'(flags), 32'(m_flags));
      check("cmp_rv", 32'(pc_redirect_valid), 32'(m_rv));
      check("cmp_pc", 32'(pc_redirect), 32'(m_pc));
      check("cmp_flush", 32'(flush), 32'(m_left > 0));
      check("cmp_busy", 32'(busy), 32'(m_left > 0));
      check("cmp_ready", 32'(br_ready), 32'(m_left == 0));
    end
  end

  task automatic idle_inputs();
    set_cond = 1'b0; br_valid = 1'b0; cond_in = '0; br_code = '0; br_target = '0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!br_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(br_ready), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_flags", 32'(flags), 32'd0);
    check("reset_ready", 32'(br_ready), 32'd1);
    check("reset_flush", 32'(flush), 32'd0);
    check("reset_rv", 32'(pc_redirect_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pc", 32'(pc_redirect), 32'd0);
    cmp_en = 1'b1;

    // Taken EQ branch with a two-cycle flush.
    set_cond = 1'b1; cond_in = 4'b0100;
    @(negedge clk);
    check("eq_flags", 32'(flags), 32'h4);
    set_cond = 1'b0; br_valid = 1'b1; br_code = 4'd0; br_target = 16'h0040;
    @(negedge clk);
    check("eq_rv", 32'(pc_redirect_valid), 32'd1);
    check("eq_pc", 32'(pc_redirect), 32'h0040);
    check("eq_flush1", 32'(flush), 32'd1);
    check("eq_ready1", 32'(br_ready), 32'd0);
    idle_inputs();
    @(negedge clk);
    check("eq_rv_pulse", 32'(pc_redirect_valid), 32'd0);
    check("eq_flush2", 32'(flush), 32'd1);
    check("eq_ready2", 32'(br_ready), 32'd0);
    check("eq_pc_hold", 32'(pc_redirect), 32'h0040);
    @(negedge clk);
    check("eq_flush3", 32'(flush), 32'd0);
    check("eq_ready3", 32'(br_ready), 32'd1);

    // Not-taken NE branch.
    br_valid = 1'b1; br_code = 4'd1; br_target = 16'h0099;
    @(negedge clk);
    check("ne_rv", 32'(pc_redirect_valid), 32'd0);
    check("ne_flush", 32'(flush), 32'd0);
    check("ne_ready", 32'(br_ready), 32'd1);
    check("ne_pc", 32'(pc_redirect), 32'h0040);

    // Same-cycle flag update and EQ branch.
    set_cond = 1'b1; cond_in = 4'b0000; br_valid = 1'b1; br_code = 4'd0; br_target = 16'h0080;
    @(negedge clk);
    idle_inputs();
    check("fwd_rv", 32'(pc_redirect_valid), FWD ? 32'd0 : 32'd1);
    check("fwd_flags", 32'(flags), 32'd0);
    wait_ready("fwd_ready_timeout");

    // Flag writes and branch held during FLUSH.
    br_valid = 1'b1; br_code = 4'd14; br_target = 16'h1234;
    @(negedge clk);
    check("hold_rv0", 32'(pc_redirect_valid), 32'd1);
    set_cond = 1'b1; cond_in = 4'b1111; br_target = 16'h5678;
    @(negedge clk);
    check("hold_flags1", 32'(flags), 32'd0);
    check("hold_rv1", 32'(pc_redirect_valid), 32'd0);
    @(negedge clk);
    check("hold_flags2", 32'(flags), 32'd0);
    check("hold_ready", 32'(br_ready), 32'd1);
    set_cond = 1'b0;
    @(negedge clk);
    check("hold_rv2", 32'(pc_redirect_valid), 32'd1);
    check("hold_pc", 32'(pc_redirect), 32'h5678);
    idle_inputs();
    wait_ready("hold_ready_timeout");

    // Reset in the first FLUSH cycle.
    set_cond = 1'b1; cond_in = 4'b1010; br_valid = 1'b1; br_code = 4'd14; br_target = 16'hBEEF;
    @(negedge clk);
    idle_inputs();
    check("rst_pre_flush", 32'(flush), 32'd1);
    check("rst_pre_flags", 32'(flags), 32'hA);
    rst_n = 1'b0;
    #1;
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_rv", 32'(pc_redirect_valid), 32'd0);
    check("rst_ready", 32'(br_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_ready_after", 32'(br_ready), 32'd1);

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 600; i++) begin
      set_cond  = ($urandom_range(0, 99) < 35);
      cond_in   = 4'($urandom);
      br_valid  = ($urandom_range(0, 99) < 50);
      br_code   = 4'($urandom);
      br_target = 16'($urandom);
      @(negedge clk);
    end
    idle_inputs();
    repeat (4) @(negedge clk);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
